// File: rtl/ref_dac_scheduler.sv
// Round-robin scheduler that serialises 16-bit words to three reference DACs
// over one shared SPI-style bus. Each channel has its own chip-select and MUX select.
module ref_dac_scheduler #(
  parameter int CLK_DIV = 5,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [2:0]  mux_in,
  output logic [2:0]  ack,
  output logic        done,
  output logic        busy,
  output logic        SDI_REF,
  output logic        CLK_REF,
  output logic        CS_REF1,
  output logic        CS_REF2,
  output logic        CS_REF3,
  output logic        MUX_REF1,
  output logic        MUX_REF2,
  output logic        MUX_REF3
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

  state_t      state, state_n;
  logic [1:0]  ptr, ptr_n;
  logic [15:0] sreg, sreg_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  hcnt, hcnt_n;
  logic [7:0]  gcnt, gcnt_n;
  logic [2:0]  ack_q, ack_n;
  logic        done_q, done_n;
  logic        busy_q, busy_n;
  logic        sdi_q, sdi_n;
  logic        sclk_q, sclk_n;
  logic [2:0]  cs_q, cs_n;
  logic [2:0]  mux_q, mux_n;

  logic        found;
  logic [1:0]  gnt;
  logic [1:0]  cand;
  logic [15:0] gnt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      sreg    <= '0;
      bit_cnt <= '0;
      hcnt    <= '0;
      gcnt    <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sdi_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= '1;
      mux_q   <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sreg    <= sreg_n;
      bit_cnt <= bit_cnt_n;
      hcnt    <= hcnt_n;
      gcnt    <= gcnt_n;
      ack_q   <= ack_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      sdi_q   <= sdi_n;
      sclk_q  <= sclk_n;
      cs_q    <= cs_n;
      mux_q   <= mux_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    hcnt_n    = hcnt;
    gcnt_n    = gcnt;
    ack_n     = '0;
    done_n    = 1'b0;
    busy_n    = busy_q;
    sdi_n     = sdi_q;
    sclk_n    = sclk_q;
    cs_n      = cs_q;
    mux_n     = mux_q;

    // Rotating priority: first requester at or after ptr wins.
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = 2'((32'(ptr) + i) % 32'd3);
      if (!found && req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    case (gnt)
      2'd0:    gnt_data = data0;
      2'd1:    gnt_data = data1;
      default: gnt_data = data2;
    endcase

    unique case (state)
      IDLE: begin
        if (found) begin
          sreg_n     = gnt_data;
          mux_n[gnt] = mux_in[gnt];
          ptr_n      = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
          ack_n[gnt] = 1'b1;
          cs_n       = '1;
          cs_n[gnt]  = 1'b0;
          sdi_n      = gnt_data[15];
          sclk_n     = 1'b0;
          busy_n     = 1'b1;
          bit_cnt_n  = '0;
          hcnt_n     = '0;
          gcnt_n     = '0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (hcnt == HALF_LAST) begin
          hcnt_n = '0;
          if (!sclk_q) begin
            sclk_n = 1'b1;
          end else begin
            // Data only moves on the falling edge so it is stable at every DAC rising edge.
            sclk_n = 1'b0;
            if (bit_cnt == 5'd15) begin
              bit_cnt_n = '0;
              state_n   = HOLD;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
              sreg_n    = {sreg[14:0], 1'b0};
              sdi_n     = sreg[14];
            end
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      HOLD: begin
        if (hcnt == HALF_LAST) begin
          hcnt_n  = '0;
          cs_n    = '1;
          done_n  = 1'b1;
          sdi_n   = 1'b0;
          gcnt_n  = '0;
          state_n = GAP;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          gcnt_n  = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign SDI_REF  = sdi_q;
  assign CLK_REF  = sclk_q;
  assign CS_REF1  = cs_q[0];
  assign CS_REF2  = cs_q[1];
  assign CS_REF3  = cs_q[2];
  assign MUX_REF1 = mux_q[0];
  assign MUX_REF2 = mux_q[1];
  assign MUX_REF3 = mux_q[2];

endmodule

// File: tb/tb_ref_dac_scheduler.sv
// Scoreboard bench: expected frames are queued at request time; a bus monitor
// reconstructs each frame from the pins and the main sequence compares them in order.
module tb_ref_dac_scheduler;

  localparam int DA = 5;
  localparam int GA = 4;
  localparam int DB = 1;
  localparam int GB = 1;

  typedef struct {
    int          inst;
    int          ch;
    logic [15:0] word;
    int          nbits;
    int          cs_len;
    int          mux;
    int          sdi_bad;
    int          gap;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][2:0] req_v, ack_v, cs_v, mux_v;
  logic [1:0]      done_v, busy_v, sd_v, ck_v;
  logic [15:0]     data0, data1, data2;
  logic [2:0]      mux_in;

  int tests = 0;
  int fails = 0;
  frame_t exp_q[$];
  frame_t obs_q[$];

  int     done_cnt[2] = '{0, 0};
  int     multi[2]    = '{0, 0};
  int     nbits_v[2]  = '{0, 0};
  bit     in_frame[2] = '{0, 0};
  int     gap[2]      = '{1000, 1000};
  logic   pck[2]      = '{1'b0, 1'b0};
  logic   psd[2]      = '{1'b0, 1'b0};
  frame_t cur[2];

  always #5 clk = ~clk;

  ref_dac_scheduler #(.CLK_DIV(DA), .GAP_CYC(GA)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]),
    .data0(data0), .data1(data1), .data2(data2), .mux_in(mux_in),
    .ack(ack_v[0]), .done(done_v[0]), .busy(busy_v[0]),
    .SDI_REF(sd_v[0]), .CLK_REF(ck_v[0]),
    .CS_REF1(cs_v[0][0]), .CS_REF2(cs_v[0][1]), .CS_REF3(cs_v[0][2]),
    .MUX_REF1(mux_v[0][0]), .MUX_REF2(mux_v[0][1]), .MUX_REF3(mux_v[0][2])
  );

  ref_dac_scheduler #(.CLK_DIV(DB), .GAP_CYC(GB)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]),
    .data0(data0), .data1(data1), .data2(data2), .mux_in(mux_in),
    .ack(ack_v[1]), .done(done_v[1]), .busy(busy_v[1]),
    .SDI_REF(sd_v[1]), .CLK_REF(ck_v[1]),
    .CS_REF1(cs_v[1][0]), .CS_REF2(cs_v[1][1]), .CS_REF3(cs_v[1][2]),
    .MUX_REF1(mux_v[1][0]), .MUX_REF2(mux_v[1][1]), .MUX_REF3(mux_v[1][2])
  );

  // Pin-level monitor: frames are delimited by chip-select, bits taken at CLK_REF rise.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        in_frame[g] = 1'b0;
        gap[g]      = 1000;
        nbits_v[g]  = 0;
        pck[g]      = 1'b0;
        psd[g]      = 1'b0;
      end else begin
        if (done_v[g]) done_cnt[g]++;
        if ($countones(~cs_v[g]) > 1) multi[g]++;
        if (!in_frame[g]) begin
          if (cs_v[g] != 3'b111) begin
            in_frame[g]    = 1'b1;
            cur[g].inst    = g;
            cur[g].ch      = (cs_v[g] == 3'b110) ? 0 : (cs_v[g] == 3'b101) ? 1 : 2;
            cur[g].word    = '0;
            cur[g].nbits   = 0;
            cur[g].cs_len  = 1;
            cur[g].sdi_bad = 0;
            cur[g].gap     = gap[g];
            cur[g].mux     = 0;
            nbits_v[g]     = 0;
          end else begin
            gap[g]++;
          end
        end else if (cs_v[g] == 3'b111) begin
          cur[g].mux  = int'(mux_v[g][cur[g].ch]);
          obs_q.push_back(cur[g]);
          in_frame[g] = 1'b0;
          gap[g]      = 1;
        end else begin
          cur[g].cs_len++;
        end
        if (in_frame[g]) begin
          if (ck_v[g] && !pck[g]) begin
            cur[g].word = {cur[g].word[14:0], sd_v[g]};
            cur[g].nbits++;
            nbits_v[g] = cur[g].nbits;
          end
          if (ck_v[g] && (sd_v[g] != psd[g])) cur[g].sdi_bad++;
        end
        pck[g] = ck_v[g];
        psd[g] = sd_v[g];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int inst, input int ch, input logic [15:0] w, input int m);
    frame_t e;
    e.inst    = inst;
    e.ch      = ch;
    e.word    = w;
    e.nbits   = 16;
    e.cs_len  = 33 * ((inst != 0) ? DB : DA);
    e.mux     = m;
    e.sdi_bad = 0;
    e.gap     = (inst != 0) ? GB : GA;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int inst, input int ch, input bit drop);
    int n = 0;
    while (ack_v[inst] == 3'b000 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ack_onehot", 32'(ack_v[inst]), 32'(1 << ch));
    if (drop) req_v[inst][ch] = 1'b0;
    @(negedge clk);
    check("ack_width", 32'(ack_v[inst]), 32'd0);
    check("busy_in_frame", 32'(busy_v[inst]), 32'd1);
  endtask

  task automatic wait_frame();
    frame_t o, e;
    int n = 0;
    while (obs_q.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      check("frame_available", 32'(obs_q.size()), 32'(exp_q.size()));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    check("frame_inst", o.inst, e.inst);
    check("frame_ch", o.ch, e.ch);
    check("frame_word", 32'(o.word), 32'(e.word));
    check("frame_nbits", o.nbits, e.nbits);
    check("frame_cs_len", o.cs_len, e.cs_len);
    check("frame_mux", o.mux, e.mux);
    check("frame_sdi_stable", o.sdi_bad, e.sdi_bad);
    check("frame_gap_min", 32'(o.gap >= e.gap), 32'd1);
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    while (busy_v[inst] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", 32'(busy_v[inst]), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    req_v  = '0;
    data0  = '0;
    data1  = '0;
    data2  = '0;
    mux_in = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs_a",
          32'({cs_v[0], ck_v[0], sd_v[0], mux_v[0], ack_v[0], done_v[0], busy_v[0]}),
          32'(13'b111_0_0_000_000_0_0));
    check("reset_outputs_b",
          32'({cs_v[1], ck_v[1], sd_v[1], mux_v[1], ack_v[1], done_v[1], busy_v[1]}),
          32'(13'b111_0_0_000_000_0_0));
    rst_n = 1'b1;

    // Single ch0 frame with the reference word.
    data0 = 16'hA5C3;
    mux_in = 3'b001;
    req_v[0] = 3'b001;
    push_exp(0, 0, 16'hA5C3, 1);
    d0 = done_cnt[0];
    wait_ack(0, 0, 1'b1);
    wait_frame();
    repeat (2) @(negedge clk);
    check("done_once", 32'(done_cnt[0] - d0), 32'd1);
    wait_idle(0);

    // From reset, all three request together: served ch0, ch1, ch2.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data0 = 16'h8001;
    data1 = 16'h4CE2;
    data2 = 16'hF00F;
    mux_in = 3'b101;
    req_v[0] = 3'b111;
    push_exp(0, 0, 16'h8001, 1);
    push_exp(0, 1, 16'h4CE2, 0);
    push_exp(0, 2, 16'hF00F, 1);
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, k, 1'b1);
      wait_frame();
    end
    wait_idle(0);

    // Round robin: after ch0 is served, ch1 beats ch0.
    data0 = 16'h0F0F;
    mux_in = 3'b000;
    req_v[0] = 3'b001;
    push_exp(0, 0, 16'h0F0F, 0);
    wait_ack(0, 0, 1'b1);
    wait_frame();
    wait_idle(0);
    data1 = 16'h3C3C;
    mux_in = 3'b010;
    req_v[0] = 3'b011;
    push_exp(0, 1, 16'h3C3C, 1);
    push_exp(0, 0, 16'h0F0F, 0);
    wait_ack(0, 1, 1'b1);
    wait_frame();
    wait_ack(0, 0, 1'b1);
    wait_frame();
    wait_idle(0);

    // Reset in the middle of a ch2 frame.
    data2 = 16'hDEAD;
    mux_in = 3'b000;
    req_v[0] = 3'b100;
    wait_ack(0, 2, 1'b1);
    n = 0;
    while (nbits_v[0] < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bit7_reached", 32'(nbits_v[0] >= 7), 32'd1);
    d0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("async_cs", 32'(cs_v[0]), 32'(3'b111));
    check("async_clk_ref", 32'(ck_v[0]), 32'd0);
    check("async_busy", 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    check("abort_no_frame", 32'(obs_q.size()), 32'd0);
    data2 = 16'hBEEF;
    req_v[0] = 3'b100;
    push_exp(0, 2, 16'hBEEF, 0);
    wait_ack(0, 2, 1'b1);
    wait_frame();
    wait_idle(0);

    // Inputs changed mid-frame must not disturb the captured word or MUX.
    data0 = 16'h1234;
    mux_in = 3'b001;
    req_v[0] = 3'b001;
    push_exp(0, 0, 16'h1234, 1);
    wait_ack(0, 0, 1'b1);
    data0 = 16'hFFFF;
    mux_in = 3'b000;
    wait_frame();
    wait_idle(0);
    check("mux_hold", 32'(mux_v[0][0]), 32'd1);

    // Fastest configuration, back-to-back requests on ch1.
    data1 = 16'h5A96;
    mux_in = 3'b010;
    req_v[1] = 3'b010;
    push_exp(1, 1, 16'h5A96, 1);
    push_exp(1, 1, 16'h5A96, 1);
    wait_ack(1, 1, 1'b0);
    wait_ack(1, 1, 1'b1);
    wait_frame();
    wait_frame();
    wait_idle(1);

    check("no_cs_overlap_a", 32'(multi[0]), 32'd0);
    check("no_cs_overlap_b", 32'(multi[1]), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("obs_drained", 32'(obs_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
